// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit -- instruction-fetch stage.
//
// Owns the program counter, fetches over a req/ack instruction-memory port
// and presents {PC_IF, INSTRUCTION_IF} to the IF/ID pipeline register.
// A one-entry skid holds a fetch that returns while the stage is stalled.
// Redirects from EX flush everything in flight.
//
// Ports
//   clk             clock, rising edge
//   reset           asynchronous active-low reset
//   write           IF/ID write enable (0 = downstream stall)
//   branch_taken    redirect pulse from EX
//   branch_target   redirect PC, bits [1:0] forced to zero
//   imem_req/addr   fetch request and word-aligned address
//   imem_ack/rdata  fetch response (may arrive in the request cycle)
//   PC_IF           PC of the presented instruction
//   INSTRUCTION_IF  presented instruction, NOP_INSTR when if_valid=0
//   if_valid        presented instruction is real
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] PC_STEP   = 32'd4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_IF,
    output logic [31:0] INSTRUCTION_IF,
    output logic        if_valid
);

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc;
    logic [31:0] discard_addr;   // address of the request being thrown away
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;
    logic        ack_ok;
    logic        buf_free;
    logic [31:0] target_aligned;

    // A stray ack (no request outstanding) must never be taken.
    assign ack_ok         = imem_ack & imem_req;
    assign buf_free       = ~if_valid | write;
    assign target_aligned = branch_target & 32'hFFFF_FFFC;

    // ---- state register ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_REQ;
        else        state <= state_nxt;
    end

    // ---- next-state logic ----
    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ: begin
                if (branch_taken)
                    // Without an ack the old request is still in flight and
                    // must be drained before fetching the new target.
                    state_nxt = ack_ok ? S_REQ : S_DISCARD;
                else if (ack_ok && !buf_free)
                    state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (branch_taken || write) state_nxt = S_REQ;
            end
            S_DISCARD: begin
                // A further redirect only retargets pc; the drain continues.
                if (ack_ok) state_nxt = S_REQ;
            end
            default: state_nxt = S_REQ;
        endcase
    end

    // ---- outputs ----
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc;
        case (state)
            S_REQ:     imem_req = reset;
            S_DISCARD: begin
                imem_req  = reset;
                imem_addr = discard_addr;
            end
            default:   imem_req = 1'b0;
        endcase
    end

    // ---- datapath: pc, skid and output buffer ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc             <= RESET_PC;
            discard_addr   <= 32'h0;
            skid_pc        <= 32'h0;
            skid_instr     <= 32'h0;
            PC_IF          <= 32'h0;
            INSTRUCTION_IF <= NOP_INSTR;
            if_valid       <= 1'b0;
        end else if (branch_taken) begin
            // Redirect wins over stall and fetch results. The skid is
            // implicitly emptied because the FSM leaves HOLD.
            pc             <= target_aligned;
            if_valid       <= 1'b0;
            INSTRUCTION_IF <= NOP_INSTR;
            if (state == S_REQ) discard_addr <= pc;
        end else begin
            case (state)
                S_REQ: begin
                    if (ack_ok && buf_free) begin
                        PC_IF          <= pc;
                        INSTRUCTION_IF <= imem_rdata;
                        if_valid       <= 1'b1;
                        pc             <= pc + PC_STEP;
                    end else if (ack_ok) begin
                        skid_pc    <= pc;
                        skid_instr <= imem_rdata;
                        pc         <= pc + PC_STEP;
                    end else if (write) begin
                        if_valid       <= 1'b0;
                        INSTRUCTION_IF <= NOP_INSTR;
                    end
                end
                S_HOLD: begin
                    if (write) begin
                        PC_IF          <= skid_pc;
                        INSTRUCTION_IF <= skid_instr;
                        if_valid       <= 1'b1;
                    end
                end
                default: begin
                    if (write) begin
                        if_valid       <= 1'b0;
                        INSTRUCTION_IF <= NOP_INSTR;
                    end
                end
            endcase
        end
    end

endmodule
